mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 23 ++
 rtl/arb_req_latch.sv | 56 +++++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types for the memory arbiter: data word, byte-write mask and the
// arbiter FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    DONE    = 2'd3
  } lc3b_arb_state;

  // Width of the port-A starvation counter (saturates at all-ones).
  localparam int STARVE_CNT_W = 3;

  // A port is requesting when either strobe is high.
  function automatic logic port_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// One captured memory request. Loads on load_i; write wins over read, so a
// port asserting both strobes is stored as a pure write.
module arb_req_latch
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  wmask_i,
  input  logic [15:0] address_i,
  input  logic [15:0] wdata_i,
  output logic        read_o,
  output logic        write_o,
  output logic [1:0]  wmask_o,
  output logic [15:0] address_o,
  output logic [15:0] wdata_o
);

  logic      read_q;
  logic      write_q;
  lc3b_wmask wmask_q;
  lc3b_word  address_q;
  lc3b_word  wdata_q;

  // Capture the request fields on load; hold them otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      wmask_q   <= 2'b00;
      address_q <= 16'h0000;
      wdata_q   <= 16'h0000;
    end else if (load_i) begin
      read_q    <= read_i & ~write_i;
      write_q   <= write_i;
      wmask_q   <= wmask_i;
      address_q <= address_i;
      wdata_q   <= wdata_i;
    end else begin
      read_q    <= read_q;
      write_q   <= write_q;
      wmask_q   <= wmask_q;
      address_q <= address_q;
      wdata_q   <= wdata_q;
    end
  end

  assign read_o    = read_q;
  assign write_o   = write_q;
  assign wmask_o   = wmask_q;
  assign address_o = address_q;
  assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction A / data B) arbiter onto one unified memory.
// B wins ties. Optional build macro ARB_STARVE_GUARD_EN adds a counter that
// forces a pending A request through after STARVE_LIMIT contested B grants.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_a,
  input  logic        mem_write_a,
  input  logic [1:0]  mem_wmask_a,
  input  logic [15:0] mem_address_a,
  input  logic [15:0] mem_wdata_a,
  output logic        mem_resp_a,
  output logic [15:0] mem_rdata_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [1:0]  mem_wmask_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  output logic        mem_resp_b,
  output logic [15:0] mem_rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  lc3b_arb_state state_q, state_d;
  logic          req_a_s, req_b_s, force_a_s;
  logic          load_a_s, load_b_s;
  logic          sel_b_q;

  logic      a_read_s, a_write_s, b_read_s, b_write_s;
  lc3b_wmask a_wmask_s, b_wmask_s;
  lc3b_word  a_address_s, a_wdata_s, b_address_s, b_wdata_s;

  assign req_a_s  = port_req(mem_read_a, mem_write_a);
  assign req_b_s  = port_req(mem_read_b, mem_write_b);
  assign load_a_s = (state_q == IDLE) && (state_d == SERVE_A);
  assign load_b_s = (state_q == IDLE) && (state_d == SERVE_B);

  arb_req_latch u_latch_a (
    .clk(clk), .reset_n(reset_n), .load_i(load_a_s),
    .read_i(mem_read_a), .write_i(mem_write_a), .wmask_i(mem_wmask_a),
    .address_i(mem_address_a), .wdata_i(mem_wdata_a),
    .read_o(a_read_s), .write_o(a_write_s), .wmask_o(a_wmask_s),
    .address_o(a_address_s), .wdata_o(a_wdata_s)
  );

  arb_req_latch u_latch_b (
    .clk(clk), .reset_n(reset_n), .load_i(load_b_s),
    .read_i(mem_read_b), .write_i(mem_write_b), .wmask_i(mem_wmask_b),
    .address_i(mem_address_b), .wdata_i(mem_wdata_b),
    .read_o(b_read_s), .write_o(b_write_s), .wmask_o(b_wmask_s),
    .address_o(b_address_s), .wdata_o(b_wdata_s)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Count B grants taken while A was waiting; an A grant clears the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (load_a_s) begin
      starve_cnt_d = 3'd0;
    end else if (load_b_s && req_a_s && (starve_cnt_q != 3'd7)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_a_s = req_a_s && ($signed({29'd0, starve_cnt_q}) >= STARVE_LIMIT);
`else
  assign force_a_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remember which latch fed the bus last so address/wdata hold when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_b_q <= 1'b0;
    end else if (load_b_s) begin
      sel_b_q <= 1'b1;
    end else if (load_a_s) begin
      sel_b_q <= 1'b0;
    end else begin
      sel_b_q <= sel_b_q;
    end
  end

  // Next-state logic: B wins ties unless A is being forced through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_b_s && !force_a_s) begin
          state_d = SERVE_B;
        end else if (req_a_s) begin
          state_d = SERVE_A;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_A: begin
        if (pmem_resp) state_d = DONE;
        else           state_d = SERVE_A;
      end
      SERVE_B: begin
        if (pmem_resp) state_d = DONE;
        else           state_d = SERVE_B;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: strobes only while serving; fields come from the latches.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wmask   = 2'b00;
    pmem_address = sel_b_q ? b_address_s : a_address_s;
    pmem_wdata   = sel_b_q ? b_wdata_s   : a_wdata_s;
    case (state_q)
      SERVE_A: begin
        pmem_read    = a_read_s;
        pmem_write   = a_write_s;
        pmem_wmask   = a_wmask_s;
        pmem_address = a_address_s;
        pmem_wdata   = a_wdata_s;
      end
      SERVE_B: begin
        pmem_read    = b_read_s;
        pmem_write   = b_write_s;
        pmem_wmask   = b_wmask_s;
        pmem_address = b_address_s;
        pmem_wdata   = b_wdata_s;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_wmask = 2'b00;
      end
    endcase
  end

  assign mem_resp_a  = pmem_resp & (state_q == SERVE_A);
  assign mem_resp_b  = pmem_resp & (state_q == SERVE_B);
  assign mem_rdata_a = pmem_rdata;
  assign mem_rdata_b = pmem_rdata;

endmodule
